// File: rtl/adder_nb_serial.sv
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock,
// LSB digit first, behind a start/busy/done handshake with signed overflow.
module adder_nb_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("adder_nb_serial: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] next_acc;

  // Operands shift right each cycle so the active digit always sits at bit 0;
  // their MSBs are kept aside for the final overflow decision.
  always_comb begin
    dsum     = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    next_acc = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      cy       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            cy    <= sub ? ~c : c;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a <= op_a >> DIGIT;
          op_b <= op_b >> DIGIT;
          acc  <= next_acc;
          cy   <= dsum[DIGIT];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= next_acc;
            carry    <= dsum[DIGIT];
            overflow <= (a_msb == b_msb) && (next_acc[WIDTH-1] != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_nb_serial.sv
// Randomized and directed bench for adder_nb_serial on three configurations
// (8/1, 8/4, 3/1) against an integer-arithmetic reference model.
module tb_adder_nb_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v, sub_v, c_v;
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];
  logic [2:0] busy_v, done_v, carry_v, ovf_v;
  logic [7:0] sum0, sum1;
  logic [2:0] sum2;

  logic [7:0] prev_sum [3];
  logic       prev_carry [3];
  logic       prev_ovf [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_nb_serial #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .carry(carry_v[0]),
    .overflow(ovf_v[0]));

  adder_nb_serial #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .carry(carry_v[1]),
    .overflow(ovf_v[1]));

  adder_nb_serial #(.WIDTH(3), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2][2:0]),
    .b(b_v[2][2:0]), .c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
    .carry(carry_v[2]), .overflow(ovf_v[2]));

  function automatic int width_of(input int i);
    return (i == 2) ? 3 : 8;
  endfunction

  function automatic int ndig_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] sum_of(input int i);
    case (i)
      0:       return sum0;
      1:       return sum1;
      default: return {5'b0, sum2};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed/unsigned integer view of a +/- b +/- c; carry in sub mode means "no borrow".
  task automatic model(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic sub, output logic [7:0] s, output logic cout, output logic ovf);
    int m, ua, ub, sa, sb, r, sr;
    m  = 1 << width_of(i);
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      r    = ua + ub + int'(c);
      cout = (r >= m);
      sr   = sa + sb + int'(c);
    end else begin
      r    = ua - ub - int'(c);
      cout = (r >= 0);
      sr   = sa - sb - int'(c);
    end
    s   = 8'((r + m) % m);
    ovf = (sr >= m / 2) || (sr < -(m / 2));
  endtask

  // Starts an operation in the current cycle and returns #1 into its DONE cycle.
  task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic sub, input bit poke_mid);
    logic [7:0] es, mask;
    logic       ec, eo;
    mask = 8'((1 << width_of(i)) - 1);
    model(i, a & mask, b & mask, c, sub, es, ec, eo);
    a_v[i] = a & mask;
    b_v[i] = b & mask;
    c_v[i] = c;
    sub_v[i] = sub;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    for (int k = 1; k <= ndig_of(i); k++) begin
      a_v[i] = 8'($urandom) & mask;
      b_v[i] = 8'($urandom) & mask;
      c_v[i] = 1'($urandom);
      sub_v[i] = 1'($urandom);
      checkOutput($sformatf("u%0d busy run%0d", i, k), busy_v[i], 1);
      checkOutput($sformatf("u%0d done run%0d", i, k), done_v[i], 0);
      checkOutput($sformatf("u%0d hold run%0d", i, k), {sum_of(i), carry_v[i], ovf_v[i]},
                  {prev_sum[i], prev_carry[i], prev_ovf[i]});
      start_v[i] = (poke_mid && k == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start_v[i] = 1'b0;
    checkOutput($sformatf("u%0d done", i), done_v[i], 1);
    checkOutput($sformatf("u%0d busy end", i), busy_v[i], 0);
    checkOutput($sformatf("u%0d result a=%0h b=%0h c=%0b sub=%0b", i, a & mask, b & mask, c, sub),
                {sum_of(i), carry_v[i], ovf_v[i]}, {es, ec, eo});
    prev_sum[i] = es;
    prev_carry[i] = ec;
    prev_ovf[i] = eo;
  endtask

  task automatic idleGap(input int i);
    @(posedge clk); #1;
    checkOutput($sformatf("u%0d idle done", i), done_v[i], 0);
    checkOutput($sformatf("u%0d idle busy", i), busy_v[i], 0);
    checkOutput($sformatf("u%0d idle hold", i), {sum_of(i), carry_v[i], ovf_v[i]},
                {prev_sum[i], prev_carry[i], prev_ovf[i]});
  endtask

  task automatic checkAllZero(input string tag);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("%s u%0d", tag, j),
                  {busy_v[j], done_v[j], sum_of(j), carry_v[j], ovf_v[j]}, 0);
      prev_sum[j] = '0;
      prev_carry[j] = 1'b0;
      prev_ovf[j] = 1'b0;
    end
  endtask

  // Reset lands on the edge ending the second RUN cycle.
  task automatic abortTest(input int i);
    a_v[i] = 8'($urandom);
    b_v[i] = 8'($urandom);
    c_v[i] = 1'b1;
    sub_v[i] = 1'b0;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkAllZero("abort");
    for (int k = 0; k <= ndig_of(i); k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("u%0d abort no done %0d", i, k), done_v[i], 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = 3'b111;
    sub_v = '0;
    c_v = '0;
    for (int j = 0; j < 3; j++) begin
      a_v[j] = 8'($urandom);
      b_v[j] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    start_v = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("post-reset");

    applyStimulus(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("u0 FF+01", {sum0, carry_v[0], ovf_v[0]}, {8'h00, 1'b1, 1'b0});
    idleGap(0);
    applyStimulus(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("u0 7F+01", {sum0, carry_v[0], ovf_v[0]}, {8'h80, 1'b0, 1'b1});
    idleGap(0);
    applyStimulus(1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    checkOutput("u1 05-07", {sum1, carry_v[1], ovf_v[1]}, {8'hFE, 1'b0, 1'b0});
    idleGap(1);
    applyStimulus(1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    checkOutput("u1 80-01", {sum1, carry_v[1], ovf_v[1]}, {8'h7F, 1'b1, 1'b1});
    idleGap(1);

    for (int s = 0; s < 2; s++)
      for (int cc = 0; cc < 2; cc++)
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++) begin
            applyStimulus(2, 8'(x), 8'(y), 1'(cc), 1'(s), 1'b0);
            if (($urandom & 3) == 0) idleGap(2);
          end
    idleGap(2);

    repeat (60) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        if ($urandom & 1) idleGap(i);
      end
    end
    idleGap(0);
    idleGap(1);

    applyStimulus(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    idleGap(0);
    applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    idleGap(1);

    abortTest(0);
    applyStimulus(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
    idleGap(0);
    abortTest(1);
    applyStimulus(1, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    idleGap(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
